// File: rtl/mode_sorter_pkg.sv
// Shared definitions for the mode sorter: FSM state encoding, index width
// and the mode-to-block-length mapping.
package mode_sorter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN
   } state_t;

   localparam int unsigned MIN_LEN = 4;

   function automatic int unsigned idx_width(input int unsigned max_len);
      return $clog2(max_len);
   endfunction

   // Block length doubles with each mode step and never exceeds the store depth.
   function automatic int unsigned mode_len(input logic [1:0] m, input int unsigned max_len);
      int unsigned len;
      len = MIN_LEN << m;
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/mode_sorter_sort_cell.sv
// One slot of the insertion-sorted store: holds, takes the new sample, or
// takes its neighbour's entry (right shift on insert, left shift on drain).
module sort_cell
   import mode_sorter_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int IDXW    = 5,
   parameter int DESCEND = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             insert,
   input  logic             shift,
   input  logic [WIDTH-1:0] new_val,
   input  logic [IDXW-1:0]  new_idx,
   input  logic [WIDTH-1:0] prev_val,
   input  logic [IDXW-1:0]  prev_idx,
   input  logic             prev_occ,
   input  logic [WIDTH-1:0] next_val,
   input  logic [IDXW-1:0]  next_idx,
   input  logic             next_occ,
   output logic [WIDTH-1:0] val,
   output logic [IDXW-1:0]  idx,
   output logic             occ
);

   logic own_before;
   logic prev_before;

   // An entry stays ahead of the new sample when it is equal, which keeps ties in arrival order.
   assign own_before  = occ && ((DESCEND != 0) ? (val >= new_val) : (val <= new_val));
   assign prev_before = prev_occ && ((DESCEND != 0) ? (prev_val >= new_val) : (prev_val <= new_val));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val <= '0;
         idx <= '0;
         occ <= 1'b0;
      end else if (clear) begin
         val <= '0;
         idx <= '0;
         occ <= 1'b0;
      end else if (insert && !own_before) begin
         if (prev_before) begin
            val <= new_val;
            idx <= new_idx;
            occ <= 1'b1;
         end else begin
            val <= prev_val;
            idx <= prev_idx;
            occ <= prev_occ;
         end
      end else if (shift) begin
         val <= next_val;
         idx <= next_idx;
         occ <= next_occ;
      end
   end

endmodule

// File: rtl/mode_sorter.sv
// Block insertion sorter: loads LEN samples into a sorted store, then drains
// them in order with their arrival indices under valid/ready handshakes.
module mode_sorter
   import mode_sorter_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int MAX_LEN = 32,
   parameter int DESCEND = 0,
   localparam int IDXW   = idx_width(MAX_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       M,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam int LENW = IDXW + 1;
   localparam logic [WIDTH-1:0] SEED_VAL = (DESCEND != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   state_t           state;
   logic [LENW-1:0]  len;
   logic [IDXW-1:0]  count;
   logic [IDXW-1:0]  k;
   logic             accept;
   logic             handshake;
   logic             clear;
   logic             last_in;
   logic             last_out;

   logic [WIDTH-1:0] cell_val [MAX_LEN];
   logic [IDXW-1:0]  cell_idx [MAX_LEN];
   logic             cell_occ [MAX_LEN];
   logic [WIDTH-1:0] prev_val [MAX_LEN];
   logic [IDXW-1:0]  prev_idx [MAX_LEN];
   logic             prev_occ [MAX_LEN];
   logic [WIDTH-1:0] next_val [MAX_LEN];
   logic [IDXW-1:0]  next_idx [MAX_LEN];
   logic             next_occ [MAX_LEN];

   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign clear     = (state == ST_IDLE) && start;
   assign last_in   = (LENW'(count) + LENW'(1)) == len;
   assign last_out  = (LENW'(k) + LENW'(1)) == len;

   // The head slot sees a phantom occupied neighbour that always sorts first,
   // so an empty store inserts at slot 0.
   for (genvar g = 0; g < MAX_LEN; g++) begin : g_store
      if (g == 0) begin : g_head
         assign prev_val[g] = SEED_VAL;
         assign prev_idx[g] = '0;
         assign prev_occ[g] = 1'b1;
      end else begin : g_link_prev
         assign prev_val[g] = cell_val[g-1];
         assign prev_idx[g] = cell_idx[g-1];
         assign prev_occ[g] = cell_occ[g-1];
      end

      if (g == MAX_LEN - 1) begin : g_tail
         assign next_val[g] = '0;
         assign next_idx[g] = '0;
         assign next_occ[g] = 1'b0;
      end else begin : g_link_next
         assign next_val[g] = cell_val[g+1];
         assign next_idx[g] = cell_idx[g+1];
         assign next_occ[g] = cell_occ[g+1];
      end

      sort_cell #(
         .WIDTH   (WIDTH),
         .IDXW    (IDXW),
         .DESCEND (DESCEND)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .clear    (clear),
         .insert   (accept),
         .shift    (handshake),
         .new_val  (in_data),
         .new_idx  (count),
         .prev_val (prev_val[g]),
         .prev_idx (prev_idx[g]),
         .prev_occ (prev_occ[g]),
         .next_val (next_val[g]),
         .next_idx (next_idx[g]),
         .next_occ (next_occ[g]),
         .val      (cell_val[g]),
         .idx      (cell_idx[g]),
         .occ      (cell_occ[g])
      );
   end

   assign out_data = out_valid ? cell_val[0] : '0;
   assign out_idx  = out_valid ? cell_idx[0] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         len       <= '0;
         count     <= '0;
         k         <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_LOAD;
                  len      <= LENW'(mode_len(M, MAX_LEN));
                  count    <= '0;
                  k        <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  if (last_in) begin
                     state     <= ST_DRAIN;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_last  <= 1'b0;
                     k         <= '0;
                  end else begin
                     count <= count + IDXW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (handshake) begin
                  if (last_out) begin
                     state     <= ST_IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     k         <= '0;
                     count     <= '0;
                  end else begin
                     k        <= k + IDXW'(1);
                     out_last <= (LENW'(k) + LENW'(2)) == len;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mode_sorter.sv
// Self-checking bench for mode_sorter: table vectors, hand-written corner
// sequences and randomized blocks against a stable-selection reference model.
module tb_mode_sorter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  M;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
   logic [15:0] a_out_data;
   logic [4:0]  a_out_idx;
   logic        d_in_ready, d_out_valid, d_out_last, d_busy, d_done;
   logic [15:0] d_out_data;
   logic [4:0]  d_out_idx;
   logic        c_in_ready, c_out_valid, c_out_last, c_busy, c_done;
   logic [15:0] c_out_data;
   logic [3:0]  c_out_idx;

   logic        obs_in_ready, obs_out_valid, obs_out_last, obs_busy, obs_done;
   logic [15:0] obs_out_data;
   logic [4:0]  obs_out_idx;

   int sel = 0;
   int compared = 0;
   int mismatched = 0;

   logic [15:0] stim[$];
   logic [15:0] exp_d[$];
   int          exp_i[$];

   typedef struct {
      int          s;
      logic [1:0]  m;
      int          len;
      logic [15:0] in_v[8];
      logic [15:0] out_d[8];
      int          out_i[8];
   } vec_t;

   vec_t vecs[3];

   always #5 clk = ~clk;

   mode_sorter #(.WIDTH(16), .MAX_LEN(32), .DESCEND(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .M(M),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy), .done(a_done)
   );

   mode_sorter #(.WIDTH(16), .MAX_LEN(32), .DESCEND(1)) dut_d (
      .clk(clk), .rst(rst), .start(start), .M(M),
      .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
      .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
      .out_idx(d_out_idx), .out_last(d_out_last), .busy(d_busy), .done(d_done)
   );

   mode_sorter #(.WIDTH(16), .MAX_LEN(16), .DESCEND(0)) dut_c (
      .clk(clk), .rst(rst), .start(start), .M(M),
      .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .out_idx(c_out_idx), .out_last(c_out_last), .busy(c_busy), .done(c_done)
   );

   always_comb begin
      obs_in_ready  = a_in_ready;
      obs_out_valid = a_out_valid;
      obs_out_last  = a_out_last;
      obs_busy      = a_busy;
      obs_done      = a_done;
      obs_out_data  = a_out_data;
      obs_out_idx   = a_out_idx;
      if (sel == 1) begin
         obs_in_ready  = d_in_ready;
         obs_out_valid = d_out_valid;
         obs_out_last  = d_out_last;
         obs_busy      = d_busy;
         obs_done      = d_done;
         obs_out_data  = d_out_data;
         obs_out_idx   = d_out_idx;
      end else if (sel == 2) begin
         obs_in_ready  = c_in_ready;
         obs_out_valid = c_out_valid;
         obs_out_last  = c_out_last;
         obs_busy      = c_busy;
         obs_done      = c_done;
         obs_out_data  = c_out_data;
         obs_out_idx   = {1'b0, c_out_idx};
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Reference: repeatedly pick the smallest (or largest) unused sample; the
   // strict comparison leaves the earliest arrival in front on ties.
   task automatic buildExpected(input bit desc, input int len);
      bit used[64];
      int best;
      exp_d.delete();
      exp_i.delete();
      for (int j = 0; j < 64; j++) used[j] = 1'b0;
      for (int p = 0; p < len; p++) begin
         best = -1;
         for (int j = 0; j < len; j++) begin
            if (!used[j] && (best < 0 || (desc ? (stim[j] > stim[best]) : (stim[j] < stim[best]))))
               best = j;
         end
         used[best] = 1'b1;
         exp_d.push_back(stim[best]);
         exp_i.push_back(best);
      end
   endtask

   task automatic applyStimulus(input int s, input logic [1:0] m, input int len, input int ready_mode,
                                input bit poke_start, input bit gaps, input bit pre_reset);
      int acc;
      int pos;
      int cyc;
      bit hs;
      bit r;
      bit pat[4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      if (pre_reset) doReset();
      sel = s;
      @(negedge clk);
      start = 1'b1;
      M = m;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      M = 2'($urandom);
      checkOutput("load busy", 32'(obs_busy), 32'd1);
      checkOutput("load in_ready", 32'(obs_in_ready), 32'd1);

      acc = 0;
      cyc = 0;
      while (acc < len && cyc < 400) begin
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data = stim[acc];
         hs = in_valid && obs_in_ready;
         @(negedge clk);
         if (hs) acc++;
         cyc++;
      end
      if (acc < len) checkOutput("load timeout", 32'(acc), 32'(len));

      checkOutput("first out_valid", 32'(obs_out_valid), 32'd1);
      checkOutput("in_ready after last input", 32'(obs_in_ready), 32'd0);
      checkOutput("drain busy", 32'(obs_busy), 32'd1);

      pos = 0;
      cyc = 0;
      while (pos < len && cyc < 2000) begin
         checkOutput("out_valid", 32'(obs_out_valid), 32'd1);
         checkOutput("out_data", 32'(obs_out_data), 32'(exp_d[pos]));
         checkOutput("out_idx", 32'(obs_out_idx), 32'(exp_i[pos]));
         checkOutput("out_last", 32'(obs_out_last), 32'(pos == len - 1));
         checkOutput("drain in_ready", 32'(obs_in_ready), 32'd0);
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = pat[cyc % 4];
            default: r = 1'($urandom);
         endcase
         out_ready = r;
         in_valid = 1'($urandom);
         in_data = 16'($urandom);
         start = poke_start && (cyc == 1);
         M = 2'($urandom);
         @(negedge clk);
         if (r) pos++;
         cyc++;
      end
      if (pos < len) checkOutput("drain timeout", 32'(pos), 32'(len));

      checkOutput("done pulse", 32'(obs_done), 32'd1);
      checkOutput("idle out_valid", 32'(obs_out_valid), 32'd0);
      checkOutput("idle busy", 32'(obs_busy), 32'd0);
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("done single cycle", 32'(obs_done), 32'd0);
      checkOutput("still idle busy", 32'(obs_busy), 32'd0);
      checkOutput("still idle in_ready", 32'(obs_in_ready), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len;
      int s;
      logic [1:0] m;
      rst = 1'b0;
      start = 1'b0;
      M = 2'd0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;

      vecs[0].s = 0; vecs[0].m = 2'd0; vecs[0].len = 4;
      vecs[0].in_v  = '{16'd9, 16'd3, 16'd7, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
      vecs[0].out_d = '{16'd1, 16'd3, 16'd7, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0};
      vecs[0].out_i = '{3, 1, 2, 0, 0, 0, 0, 0};
      vecs[1].s = 0; vecs[1].m = 2'd1; vecs[1].len = 8;
      vecs[1].in_v  = '{16'd5, 16'd5, 16'd2, 16'd5, 16'd0, 16'd8, 16'd2, 16'd1};
      vecs[1].out_d = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd5, 16'd5, 16'd5, 16'd8};
      vecs[1].out_i = '{4, 7, 2, 6, 0, 1, 3, 5};
      vecs[2].s = 1; vecs[2].m = 2'd0; vecs[2].len = 4;
      vecs[2].in_v  = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'd0, 16'd0, 16'd0, 16'd0};
      vecs[2].out_d = '{16'hFFFF, 16'h8000, 16'h0001, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0};
      vecs[2].out_i = '{1, 2, 3, 0, 0, 0, 0, 0};

      @(negedge clk);
      checkOutput("reset in_ready", 32'(obs_in_ready), 32'd0);
      checkOutput("reset out_valid", 32'(obs_out_valid), 32'd0);
      checkOutput("reset busy", 32'(obs_busy), 32'd0);
      checkOutput("reset done", 32'(obs_done), 32'd0);
      checkOutput("reset out_data", 32'(obs_out_data), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 3; v++) begin
         stim.delete();
         exp_d.delete();
         exp_i.delete();
         for (int j = 0; j < vecs[v].len; j++) begin
            stim.push_back(vecs[v].in_v[j]);
            exp_d.push_back(vecs[v].out_d[j]);
            exp_i.push_back(vecs[v].out_i[j]);
         end
         applyStimulus(vecs[v].s, vecs[v].m, vecs[v].len, 0, 1'b0, 1'b0, 1'b1);
      end

      // M=3 on the 16-deep instance must stop accepting after 16 samples.
      stim.delete();
      for (int j = 0; j < 16; j++) stim.push_back(16'($urandom_range(0, 20)));
      buildExpected(1'b0, 16);
      applyStimulus(2, 2'd3, 16, 0, 1'b0, 1'b0, 1'b1);

      // Stall pattern 1,0,0,1 with a start pulse landing mid-drain.
      stim.delete();
      for (int j = 0; j < 8; j++) stim.push_back(16'($urandom_range(0, 5)));
      buildExpected(1'b0, 8);
      applyStimulus(0, 2'd1, 8, 1, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of a load, then a fresh block.
      doReset();
      sel = 0;
      @(negedge clk);
      start = 1'b1;
      M = 2'd0;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 16'd11;
      @(negedge clk);
      in_data = 16'd13;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("midload reset in_ready", 32'(obs_in_ready), 32'd0);
      checkOutput("midload reset out_valid", 32'(obs_out_valid), 32'd0);
      checkOutput("midload reset out_last", 32'(obs_out_last), 32'd0);
      checkOutput("midload reset busy", 32'(obs_busy), 32'd0);
      checkOutput("midload reset out_data", 32'(obs_out_data), 32'd0);
      checkOutput("midload reset out_idx", 32'(obs_out_idx), 32'd0);
      @(negedge clk);
      checkOutput("midload reset done", 32'(obs_done), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("post reset done", 32'(obs_done), 32'd0);
      stim.delete();
      exp_d.delete();
      exp_i.delete();
      stim = '{16'd4, 16'd2, 16'd6, 16'd0};
      exp_d = '{16'd0, 16'd2, 16'd4, 16'd6};
      exp_i = '{3, 1, 0, 2};
      applyStimulus(0, 2'd0, 4, 0, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         s = $urandom_range(0, 2);
         m = 2'($urandom);
         len = 4 << m;
         if (s == 2 && len > 16) len = 16;
         stim.delete();
         for (int j = 0; j < len; j++) begin
            if (t % 2 == 0) stim.push_back(16'($urandom_range(0, 7)));
            else stim.push_back(16'($urandom));
         end
         buildExpected(s == 1, len);
         applyStimulus(s, m, len, 2, 1'b0, 1'b1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
